// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with 3-sample majority vote and configurable frame format.
// Define UART_RX_BREAK_DET_EN to add the BREAK_DET strobe and suppress VALID_RX on break frames.
module uart_rx_os #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  par_EN,
  input  logic                  par_TYP,
  output logic [DATA_WIDTH-1:0] RXDATA,
  output logic                  VALID_RX,
  output logic                  PARITY_ERROR,
  output logic                  STOP_ERROR,
`ifdef UART_RX_BREAK_DET_EN
  output logic                  BREAK_DET,
`endif
  output logic                  busy
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  SMP_A     = OS_W'(OVERSAMPLE / 2 - 2);
  localparam logic [OS_W-1:0]  SMP_B     = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  SMP_C     = OS_W'(OVERSAMPLE / 2);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_WIDTH - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  function automatic logic f_maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic f_parity(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction

  logic                  r_sync1, r_sync2, r_prev;
  logic [2:0]            r_state;
  logic [DIV_W-1:0]      r_div_cnt;
  logic [OS_W-1:0]       r_os_cnt;
  logic [3:0]            r_bit_cnt;
  logic [1:0]            r_smp;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_en, r_par_typ, r_par_err, r_stop_err;
`ifdef UART_RX_BREAK_DET_EN
  logic                  r_par_bit;
  logic                  w_break;
`endif

  logic w_tick, w_start, w_smp_shift, w_vote_done, w_vote;

  // Ticks stop while idle; samples are taken as the tick counter steps onto OS/2-1, OS/2, OS/2+1.
  assign w_tick      = busy & (r_div_cnt == {DIV_W{1'b0}});
  assign w_start     = (r_state == S_IDLE) & r_prev & ~r_sync2;
  assign w_smp_shift = w_tick & ((r_os_cnt == SMP_A) | (r_os_cnt == SMP_B));
  assign w_vote_done = w_tick & (r_os_cnt == SMP_C);
  assign w_vote      = f_maj3(r_smp[1], r_smp[0], r_sync2);
`ifdef UART_RX_BREAK_DET_EN
  assign w_break     = (r_bit_cnt == 4'd0) & (r_shift == {DATA_WIDTH{1'b0}}) & ~w_vote
                       & ~(r_par_en & r_par_bit);
`endif

  // Line synchroniser and previous-value register for falling-edge detection.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= RX_IN;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Baud tick divider and oversample counter, realigned to each detected start edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_div_cnt <= {DIV_W{1'b0}};
      r_os_cnt  <= {OS_W{1'b0}};
      r_smp     <= 2'b00;
    end else begin
      if (w_start) begin
        r_div_cnt <= DIV_LAST;
        r_os_cnt  <= {OS_W{1'b0}};
      end else if (w_tick) begin
        r_div_cnt <= DIV_LAST;
        r_os_cnt  <= (r_os_cnt == OS_LAST) ? {OS_W{1'b0}} : r_os_cnt + {{(OS_W-1){1'b0}}, 1'b1};
      end else if (busy) begin
        r_div_cnt <= r_div_cnt - {{(DIV_W-1){1'b0}}, 1'b1};
      end
      if (w_smp_shift) begin
        r_smp <= {r_smp[0], r_sync2};
      end
    end
  end

  // Frame FSM: collects voted bits, accumulates errors and publishes the completed frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= 4'd0;
      r_shift      <= {DATA_WIDTH{1'b0}};
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_par_err    <= 1'b0;
      r_stop_err   <= 1'b0;
      RXDATA       <= {DATA_WIDTH{1'b0}};
      VALID_RX     <= 1'b0;
      PARITY_ERROR <= 1'b0;
      STOP_ERROR   <= 1'b0;
      busy         <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      r_par_bit    <= 1'b0;
      BREAK_DET    <= 1'b0;
`endif
    end else begin
      VALID_RX <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      BREAK_DET <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state    <= S_START;
            busy       <= 1'b1;
            r_par_en   <= par_EN;
            r_par_typ  <= par_TYP;
            r_par_err  <= 1'b0;
            r_stop_err <= 1'b0;
          end
        end
        S_START: begin
          if (w_vote_done) begin
            if (w_vote) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end else begin
              r_state   <= S_DATA;
              r_bit_cnt <= 4'd0;
            end
          end
        end
        S_DATA: begin
          if (w_vote_done) begin
            r_shift <= {w_vote, r_shift[DATA_WIDTH-1:1]};
            if (r_bit_cnt == DATA_LAST) begin
              r_bit_cnt <= 4'd0;
              r_state   <= r_par_en ? S_PARITY : S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (w_vote_done) begin
            r_par_err <= f_parity(r_shift) ^ w_vote ^ r_par_typ;
`ifdef UART_RX_BREAK_DET_EN
            r_par_bit <= w_vote;
`endif
            r_state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_vote_done) begin
`ifdef UART_RX_BREAK_DET_EN
            if (w_break) begin
              BREAK_DET  <= 1'b1;
              STOP_ERROR <= 1'b1;
              r_state    <= S_IDLE;
              busy       <= 1'b0;
            end else
`endif
            if (r_bit_cnt == STOP_LAST) begin
              RXDATA       <= r_shift;
              PARITY_ERROR <= r_par_err;
              STOP_ERROR   <= r_stop_err | ~w_vote;
              VALID_RX     <= 1'b1;
              r_state      <= S_IDLE;
              busy         <= 1'b0;
            end else begin
              r_stop_err <= r_stop_err | ~w_vote;
              r_bit_cnt  <= r_bit_cnt + 4'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os at 50 MHz / 115200 baud (432 clocks per bit).
// Directed frames plus randomized frames, scored against a queue-based frame model.
module tb_uart_rx_os;

  localparam int BIT = 432;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       par_en, par_typ;
  logic [7:0] rxdata;
  logic       valid_rx, parity_error, stop_error, busy;
`ifdef UART_RX_BREAK_DET_EN
  logic       break_det;
  int         n_break = 0;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_valid = 0;
  logic prev_valid = 1'b0;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       se;
  } exp_t;
  exp_t exp_q[$];

  uart_rx_os #(
    .CLK_FREQ(50_000_000), .BAUD(115200), .OVERSAMPLE(16), .DATA_WIDTH(8), .STOP_BITS(1)
  ) dut (
    .CLK(clk), .RST(rst_n), .RX_IN(rx), .par_EN(par_en), .par_TYP(par_typ),
    .RXDATA(rxdata), .VALID_RX(valid_rx), .PARITY_ERROR(parity_error),
    .STOP_ERROR(stop_error),
`ifdef UART_RX_BREAK_DET_EN
    .BREAK_DET(break_det),
`endif
    .busy(busy)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Parity error if data ones + parity bit do not have the parity the type asks for.
  function automatic logic ref_par_err(input logic [7:0] d, input logic pbit, input logic typ);
    int ones;
    ones = $countones(d) + int'(pbit) + int'(typ);
    return (ones % 2) == 1;
  endfunction

  // Frame scoreboard: every VALID_RX must match the oldest expected frame.
  always @(negedge clk) begin
    prev_valid <= valid_rx;
    if (valid_rx) begin
      n_valid <= n_valid + 1;
      check("valid_one_cycle", prev_valid, 1'b0);
      check("valid_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        check("sb_rxdata", rxdata, exp_q[0].d);
        check("sb_parity_err", parity_error, exp_q[0].pe);
        check("sb_stop_err", stop_error, exp_q[0].se);
        void'(exp_q.pop_front());
      end
    end
`ifdef UART_RX_BREAK_DET_EN
    if (break_det) n_break <= n_break + 1;
`endif
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic en, input logic typ, input logic pbit,
                      input logic s0, input logic scramble);
    exp_t e;
    e.d  = d;
    e.pe = en ? ref_par_err(d, pbit, typ) : 1'b0;
    e.se = ~s0;
    par_en  = en;
    par_typ = typ;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_bit(d[i]);
      if (scramble && i == 2) begin
        par_en  = 1'($urandom);
        par_typ = 1'($urandom);
      end
    end
    if (en) drive_bit(pbit);
    drive_bit(s0);
  endtask

  task automatic frame_done(input string tag, input int nv_before);
    idle(BIT / 4);
    check({tag, "_strobes"}, n_valid - nv_before, 1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    int         nv, cyc;
    logic [7:0] snap_d, d55, rd;
    logic       snap_pe, snap_se, en, typ, pb, s0;
`ifdef UART_RX_BREAK_DET_EN
    int         nb;
`endif
    rx = 1'b1; par_en = 1'b0; par_typ = 1'b0; rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_rxdata", rxdata, 8'h00);
    check("rst_valid", valid_rx, 1'b0);
    check("rst_perr", parity_error, 1'b0);
    check("rst_serr", stop_error, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    idle(20);

    nv = n_valid; send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); frame_done("a5", nv);
    check("a5_rxdata", rxdata, 8'hA5);
    nv = n_valid; send(8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); frame_done("f0_ok", nv);
    check("f0_ok_perr", parity_error, 1'b0);
    nv = n_valid; send(8'hF0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); frame_done("f0_bad", nv);
    check("f0_bad_perr", parity_error, 1'b1);
    check("f0_bad_rxdata", rxdata, 8'hF0);
    nv = n_valid; send(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); frame_done("01_odd", nv);
    check("01_odd_perr", parity_error, 1'b0);
    nv = n_valid; send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); frame_done("3c_stop", nv);
    check("3c_stop_serr", stop_error, 1'b1);
    nv = n_valid; send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); frame_done("3c_clean", nv);
    check("3c_clean_serr", stop_error, 1'b0);

    // Short low glitch: must be rejected as a false start.
    snap_d = rxdata; snap_pe = parity_error; snap_se = stop_error; nv = n_valid; cyc = 0;
    rx = 1'b0;
    for (int i = 0; i < 100; i++) begin @(negedge clk); if (busy) cyc++; end
    rx = 1'b1;
    for (int i = 0; i < BIT + BIT / 2; i++) begin @(negedge clk); if (busy) cyc++; end
    check("glitch_busy_pulse", (cyc > 0) && (cyc <= BIT), 1'b1);
    check("glitch_no_valid", n_valid - nv, 0);
    check("glitch_rxdata", rxdata, snap_d);
    check("glitch_flags", {parity_error, stop_error}, {snap_pe, snap_se});
    check("glitch_busy_end", busy, 1'b0);

    // Reset in the middle of bit 3 of 0x55.
    d55 = 8'h55; par_en = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d55[i]);
    rx = d55[3];
    repeat (BIT / 2) @(negedge clk);
    check("midrst_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_rxdata", rxdata, 8'h00);
    check("midrst_outs", {valid_rx, parity_error, stop_error, busy}, 4'b0000);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    nv = n_valid; send(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); frame_done("81_after_rst", nv);
    check("81_rxdata", rxdata, 8'h81);
    check("81_flags", {parity_error, stop_error}, 2'b00);

    // Line held low for 12 bit times.
    par_en = 1'b0; nv = n_valid;
`ifdef UART_RX_BREAK_DET_EN
    nb = n_break;
`else
    exp_q.push_back('{d: 8'h00, pe: 1'b0, se: 1'b1});
`endif
    rx = 1'b0;
    repeat (12 * BIT) @(negedge clk);
    check("break_busy_low", busy, 1'b0);
    idle(BIT);
    check("break_serr", stop_error, 1'b1);
    check("break_pending", exp_q.size(), 0);
`ifdef UART_RX_BREAK_DET_EN
    check("break_pulses", n_break - nb, 1);
    check("break_no_valid", n_valid - nv, 0);
    check("break_rxdata_kept", rxdata, 8'h81);
`else
    check("break_valid_once", n_valid - nv, 1);
    check("break_rxdata", rxdata, 8'h00);
`endif
    nv = n_valid; send(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); frame_done("5a_recover", nv);
    check("5a_serr", stop_error, 1'b0);

    // Random frames, mid-frame parity-control changes, some back-to-back.
    for (int i = 0; i < 4; i++) begin
      rd  = 8'($urandom);
      en  = 1'($urandom);
      typ = 1'($urandom);
      pb  = 1'($urandom);
      s0  = ($urandom_range(0, 3) != 0);
      if (!s0 && rd == 8'h00) rd = 8'h01;
      send(rd, en, typ, pb, s0, 1'b1);
      if (!(s0 && (i % 2 == 0))) idle(BIT / 2);
    end
    idle(BIT / 4);
    check("final_pending", exp_q.size(), 0);
    check("final_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
